// File: rtl/atm_pkg.sv
// Shared key-code constants and debounce state encoding for the ATM keypad.
package atm_pkg;

  localparam logic [3:0] KEY_CLEAR     = 4'd10;
  localparam logic [3:0] KEY_ENTER     = 4'd11;
  localparam logic [3:0] KEY_BACKSPACE = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } deb_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_keypad_if.sv
// Keypad-side inputs and registered action outputs of atm_keypad.
interface atm_keypad_if;
  logic        keyValid;
  logic [3:0]  keyCode;
  logic        pinMode;
  logic        stbDigit;
  logic [3:0]  digit;
  logic        stbAmount;
  logic [31:0] amount;
  logic [3:0]  digitCount;

  modport master (
    output keyValid, keyCode, pinMode,
    input  stbDigit, digit, stbAmount, amount, digitCount
  );

  modport slave (
    input  keyValid, keyCode, pinMode,
    output stbDigit, digit, stbAmount, amount, digitCount
  );
endinterface

// File: rtl/keypad_debounce.sv
// Press/release debouncer: emits a one-cycle o_keyAccept per stable press,
// with the code latched at the start of the press.
module keypad_debounce
  import atm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_keyValid,
  input  logic [3:0] i_keyCode,
  output logic       o_keyAccept,
  output logic [3:0] o_keyCode
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE_CYCLES);

  deb_state_t r_state, w_state_n;
  logic [3:0] r_cnt, w_cnt_n;
  logic [3:0] r_code, w_code_n;
  logic       r_accept, w_accept_n;
  logic [3:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 4'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_code   <= 4'd0;
      r_accept <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_code   <= w_code_n;
      r_accept <= w_accept_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_code_n   = r_code;
    w_accept_n = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_keyValid) begin
          w_code_n = i_keyCode;
          if (DEB <= 4'd1) begin
            w_state_n  = ST_HELD;
            w_cnt_n    = 4'd0;
            w_accept_n = 1'b1;
          end else begin
            w_state_n = ST_PRESS;
            w_cnt_n   = 4'd1;
          end
        end
      end
      ST_PRESS: begin
        // A code change mid-press is treated as a new, not-yet-stable press.
        if (i_keyValid && i_keyCode == r_code) begin
          if (w_cnt_inc >= DEB) begin
            w_state_n  = ST_HELD;
            w_cnt_n    = 4'd0;
            w_accept_n = 1'b1;
          end else begin
            w_cnt_n = w_cnt_inc;
          end
        end else begin
          w_state_n = ST_IDLE;
          w_cnt_n   = 4'd0;
        end
      end
      ST_HELD: begin
        if (!i_keyValid) begin
          if (DEB <= 4'd1) begin
            w_state_n = ST_IDLE;
            w_cnt_n   = 4'd0;
          end else begin
            w_state_n = ST_RELEASE;
            w_cnt_n   = 4'd1;
          end
        end
      end
      ST_RELEASE: begin
        if (i_keyValid) begin
          w_state_n = ST_HELD;
          w_cnt_n   = 4'd0;
        end else if (w_cnt_inc >= DEB) begin
          w_state_n = ST_IDLE;
          w_cnt_n   = 4'd0;
        end else begin
          w_cnt_n = w_cnt_inc;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_cnt_n   = 4'd0;
      end
    endcase
  end

  assign o_keyAccept = r_accept;
  assign o_keyCode   = r_code;

endmodule

// File: rtl/atm_keypad.sv
// ATM keypad front end: debounced keys drive PIN digit strobes or a decimal
// amount accumulator. Optional BACKSPACE support via ATM_KEYPAD_BACKSPACE_EN.
module atm_keypad
  import atm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 9
) (
  input  logic         clock,
  input  logic         reset,
  atm_keypad_if.slave  kp
);

  localparam logic [3:0] MAXD = 4'(MAX_DIGITS);

  logic        w_accept;
  logic [3:0]  w_code;

  logic        r_stbDigit;
  logic [3:0]  r_digit;
  logic        r_stbAmount;
  logic [31:0] r_amount;
  logic [31:0] r_acc;
  logic [3:0]  r_cnt;
  logic        r_pin_prev;

  keypad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clock       (clock),
    .reset       (reset),
    .i_keyValid  (kp.keyValid),
    .i_keyCode   (kp.keyCode),
    .o_keyAccept (w_accept),
    .o_keyCode   (w_code)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stbDigit  <= 1'b0;
      r_digit     <= 4'd0;
      r_stbAmount <= 1'b0;
      r_amount    <= 32'd0;
      r_acc       <= 32'd0;
      r_cnt       <= 4'd0;
      r_pin_prev  <= kp.pinMode;
    end else begin
      r_stbDigit  <= 1'b0;
      r_stbAmount <= 1'b0;
      r_pin_prev  <= kp.pinMode;
      // A mode switch wins over any key accepted in the same cycle.
      if (kp.pinMode != r_pin_prev) begin
        r_acc <= 32'd0;
        r_cnt <= 4'd0;
      end else if (w_accept) begin
        if (is_digit(w_code)) begin
          if (kp.pinMode) begin
            r_stbDigit <= 1'b1;
            r_digit    <= w_code;
          end else if (r_cnt < MAXD) begin
            r_acc <= r_acc * 32'd10 + {28'd0, w_code};
            r_cnt <= r_cnt + 4'd1;
          end
        end else begin
          case (w_code)
            KEY_CLEAR: begin
              r_acc <= 32'd0;
              r_cnt <= 4'd0;
            end
            KEY_ENTER: begin
              if (!kp.pinMode && r_cnt != 4'd0) begin
                r_amount    <= r_acc;
                r_stbAmount <= 1'b1;
                r_acc       <= 32'd0;
                r_cnt       <= 4'd0;
              end
            end
`ifdef ATM_KEYPAD_BACKSPACE_EN
            KEY_BACKSPACE: begin
              if (!kp.pinMode && r_cnt != 4'd0) begin
                r_acc <= r_acc / 32'd10;
                r_cnt <= r_cnt - 4'd1;
              end
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  assign kp.stbDigit   = r_stbDigit;
  assign kp.digit      = r_digit;
  assign kp.stbAmount  = r_stbAmount;
  assign kp.amount     = r_amount;
  assign kp.digitCount = r_cnt;

endmodule

// File: doc/atm_keypad.md
ATM_KEYPAD -- requirements
Module: atm_keypad

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable samples needed to accept a press or a release (range 1..15).
REQ-002 Parameter MAX_DIGITS, default 9: maximum decimal digits accumulated into an amount (range 1..9).
REQ-003 clock  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 keyValid  input  1  raw, undebounced "key held" level from the keypad.
REQ-006 keyCode  input  4  raw key code: 0-9 digits, 10 CLEAR, 11 ENTER, 12 BACKSPACE, 13-15 invalid.
REQ-007 pinMode  input  1  1 = PIN entry (digits forwarded), 0 = amount entry (digits accumulated).
REQ-008 stbDigit  output  1  one-cycle strobe: digit valid (PIN mode only).
REQ-009 digit  output  4  accepted digit value; holds until the next stbDigit.
REQ-010 stbAmount  output  1  one-cycle strobe: amount valid.
REQ-011 amount  output  32  binary amount; holds until the next stbAmount.
REQ-012 digitCount  output  4  number of digits currently in the accumulator.

Function
REQ-013 Debounce FSM SHALL have states IDLE, PRESS, HELD and RELEASE.
REQ-014 IDLE->PRESS on keyValid=1; the code is latched and the counter set to 1.
REQ-015 In PRESS, each cycle with keyValid=1 and an unchanged keyCode increments the counter; keyValid=0 or a changed code returns to IDLE.
REQ-016 When the counter reaches DEBOUNCE_CYCLES, the key is accepted and the FSM enters HELD; the action output is registered one cycle after acceptance.
REQ-017 HELD->RELEASE on keyValid=0; RELEASE->IDLE after DEBOUNCE_CYCLES consecutive keyValid=0 samples; any keyValid=1 in RELEASE returns to HELD.
REQ-018 Exactly one action per press, regardless of hold duration.
REQ-019 PIN mode, digit accepted: stbDigit=1 for one cycle; digit=code; the accumulator is untouched.
REQ-020 Amount mode, digit accepted with digitCount<MAX_DIGITS: acc=acc*10+code and digitCount+1. At MAX_DIGITS the digit is ignored with no overflow and no strobe.
REQ-021 CLEAR: acc=0 and digitCount=0, in either mode; no strobe.
REQ-022 ENTER in amount mode with digitCount>0: amount=acc and stbAmount=1 for one cycle; acc and digitCount cleared in the same cycle.
REQ-023 ENTER with digitCount=0, or in PIN mode: ignored.
REQ-024 Invalid codes 13-15 are debounced normally, then ignored.
REQ-025 A change on pinMode, in either direction, clears acc and digitCount on the next edge; the FSM is unaffected.
REQ-026 stbDigit and stbAmount are never high in the same cycle.
REQ-027 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-028 While reset=1 at an edge: FSM=IDLE; counter, acc, digitCount, digit and amount = 0; stbDigit=stbAmount=0.
REQ-029 Reset mid-debounce or mid-hold aborts the press; no strobe is emitted afterwards for that press.

Configuration
REQ-030 Macro ATM_KEYPAD_BACKSPACE_EN.
- Defined: BACKSPACE in amount mode with digitCount>0 sets acc=acc/10 (integer) and digitCount-1; otherwise ignored.
- Undefined: code 12 is treated as invalid, per REQ-024.

Structure
REQ-031 Shared package atm_pkg SHALL hold the key code constants (KEY_CLEAR=10, KEY_ENTER=11, KEY_BACKSPACE=12) and the debounce state encoding.
REQ-032 Debounce FSM plus counter SHALL be a sub-module keypad_debounce, outputting a one-cycle keyAccept with the latched keyCode; atm_keypad holds mode and accumulator logic.

Verification (DEBOUNCE_CYCLES=4, MAX_DIGITS=9)
REQ-033 pinMode=1, code 7 held 10 cycles -> exactly one stbDigit, one cycle after the 4th stable sample, digit=7.
REQ-034 pinMode=1, keyValid pulsed high 3 cycles, then low -> no stbDigit; FSM back in IDLE.
REQ-035 pinMode=0, keys 1,2,5,0, ENTER -> stbAmount once, amount=1250, digitCount=0 after.
REQ-036 pinMode=0, 10 presses of key 9, then ENTER -> amount=999999999; the 10th digit is ignored.
REQ-037 pinMode=0, keys 4,2, CLEAR, 3, ENTER -> amount=3. With the macro: keys 4,2, BACKSPACE, ENTER -> amount=4.
REQ-038 Reset asserted during the HELD state of key 5 -> all outputs 0 and no strobe; the next clean press of 6 with pinMode=1 -> digit=6.
